// File: rtl/rob_if.sv
// rob_if: allocation, completion and retirement signals of the reorder buffer.
interface rob_if #(parameter int ROB_SIZE_BITS = 4);
  logic                     alloc_a_valid, alloc_b_valid;
  logic                     alloc_a_has_dest, alloc_b_has_dest;
  logic [5:0]               alloc_a_old_phys, alloc_b_old_phys;
  logic [31:0]              alloc_a_pc, alloc_b_pc;
  logic                     alloc_ready;
  logic [ROB_SIZE_BITS-1:0] alloc_a_rob, alloc_b_rob;
  logic                     complete0_valid, complete1_valid, complete2_valid;
  logic [ROB_SIZE_BITS-1:0] complete0_rob, complete1_rob, complete2_rob;
  logic                     retire_a_valid, retire_b_valid;
  logic                     retire_a_has_dest, retire_b_has_dest;
  logic [5:0]               retire_a_old_phys, retire_b_old_phys;
  logic [31:0]              retire_a_pc, retire_b_pc;
  logic [ROB_SIZE_BITS:0]   count;
  modport master (
    output alloc_a_valid, alloc_b_valid, alloc_a_has_dest, alloc_b_has_dest,
           alloc_a_old_phys, alloc_b_old_phys, alloc_a_pc, alloc_b_pc,
           complete0_valid, complete1_valid, complete2_valid,
           complete0_rob, complete1_rob, complete2_rob,
    input  alloc_ready, alloc_a_rob, alloc_b_rob,
           retire_a_valid, retire_b_valid, retire_a_has_dest, retire_b_has_dest,
           retire_a_old_phys, retire_b_old_phys, retire_a_pc, retire_b_pc, count
  );
  modport slave (
    input  alloc_a_valid, alloc_b_valid, alloc_a_has_dest, alloc_b_has_dest,
           alloc_a_old_phys, alloc_b_old_phys, alloc_a_pc, alloc_b_pc,
           complete0_valid, complete1_valid, complete2_valid,
           complete0_rob, complete1_rob, complete2_rob,
    output alloc_ready, alloc_a_rob, alloc_b_rob,
           retire_a_valid, retire_b_valid, retire_a_has_dest, retire_b_has_dest,
           retire_a_old_phys, retire_b_old_phys, retire_a_pc, retire_b_pc, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB, 2-wide in-order allocate/retire, 3 out-of-order completion ports.
module reorder_buffer #(
  parameter int ROB_SIZE_BITS = 4
) (
  input logic  clk,
  input logic  reset,
  rob_if.slave rob
);
  localparam int DEPTH = 1 << ROB_SIZE_BITS;
  localparam int CW = ROB_SIZE_BITS + 1;
  typedef logic [ROB_SIZE_BITS-1:0] idx_t;
  logic [DEPTH-1:0] valid, done, has_dest;
  logic [5:0]       old_phys [DEPTH];
  logic [31:0]      pc [DEPTH];
  idx_t             head, tail, head1, tail1;
  logic [CW-1:0]    count_q;
  logic             acc_a, acc_b, ret_a, ret_b;
  logic [2:0]       cv;
  idx_t             cr [3];
  assign head1 = head + idx_t'(1);
  assign tail1 = tail + idx_t'(1);
  assign rob.alloc_ready = count_q <= CW'(DEPTH - 2);
  assign rob.alloc_a_rob = tail;
  assign rob.alloc_b_rob = tail1;
  assign rob.count = count_q;
  assign acc_a = rob.alloc_a_valid && rob.alloc_ready;
  assign acc_b = acc_a && rob.alloc_b_valid;
  assign ret_a = valid[head] && done[head];
  assign ret_b = ret_a && valid[head1] && done[head1];
  assign cv = {rob.complete2_valid, rob.complete1_valid, rob.complete0_valid};
  assign cr[0] = rob.complete0_rob;
  assign cr[1] = rob.complete1_rob;
  assign cr[2] = rob.complete2_rob;
  // Completion, then retire-clear, then allocate: later writes win for the same entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      done <= '0;
      head <= '0;
      tail <= '0;
      count_q <= '0;
      rob.retire_a_valid <= 1'b0;
      rob.retire_b_valid <= 1'b0;
      rob.retire_a_has_dest <= 1'b0;
      rob.retire_b_has_dest <= 1'b0;
      rob.retire_a_old_phys <= '0;
      rob.retire_b_old_phys <= '0;
      rob.retire_a_pc <= '0;
      rob.retire_b_pc <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (cv[i] && valid[cr[i]]) done[cr[i]] <= 1'b1;
      rob.retire_a_valid <= ret_a;
      rob.retire_b_valid <= ret_b;
      if (ret_a) begin
        valid[head] <= 1'b0;
        done[head] <= 1'b0;
        rob.retire_a_has_dest <= has_dest[head];
        rob.retire_a_old_phys <= old_phys[head];
        rob.retire_a_pc <= pc[head];
      end
      if (ret_b) begin
        valid[head1] <= 1'b0;
        done[head1] <= 1'b0;
        rob.retire_b_has_dest <= has_dest[head1];
        rob.retire_b_old_phys <= old_phys[head1];
        rob.retire_b_pc <= pc[head1];
      end
      if (acc_a) begin
        valid[tail] <= 1'b1;
        done[tail] <= 1'b0;
        has_dest[tail] <= rob.alloc_a_has_dest;
        old_phys[tail] <= rob.alloc_a_old_phys;
        pc[tail] <= rob.alloc_a_pc;
      end
      if (acc_b) begin
        valid[tail1] <= 1'b1;
        done[tail1] <= 1'b0;
        has_dest[tail1] <= rob.alloc_b_has_dest;
        old_phys[tail1] <= rob.alloc_b_old_phys;
        pc[tail1] <= rob.alloc_b_pc;
      end
      head <= ret_b ? head + idx_t'(2) : ret_a ? head1 : head;
      tail <= acc_b ? tail + idx_t'(2) : acc_a ? tail1 : tail;
      count_q <= count_q + CW'(acc_a) + CW'(acc_b) - CW'(ret_a) - CW'(ret_b);
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench; a small occupancy model predicts retirements, a queue holds retire data.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  rob_if #(.ROB_SIZE_BITS(4)) ifc ();
  reorder_buffer #(.ROB_SIZE_BITS(4)) dut (.clk(clk), .reset(reset), .rob(ifc));
  int errors = 0;
  int checks = 0;
  logic [38:0] sb [$];
  logic mv [16];
  logic md [16];
  logic [3:0] m_head = 4'd0;
  logic [3:0] m_tail = 4'd0;
  int m_cnt = 0;
  logic [31:0] next_pc = 32'd0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_inputs();
    ifc.alloc_a_valid = 0; ifc.alloc_b_valid = 0;
    ifc.alloc_a_has_dest = 0; ifc.alloc_b_has_dest = 0;
    ifc.alloc_a_old_phys = 0; ifc.alloc_b_old_phys = 0;
    ifc.alloc_a_pc = 0; ifc.alloc_b_pc = 0;
    ifc.complete0_valid = 0; ifc.complete1_valid = 0; ifc.complete2_valid = 0;
    ifc.complete0_rob = 0; ifc.complete1_rob = 0; ifc.complete2_rob = 0;
    reset = 0;
  endtask
  task automatic set_alloc(input logic a, input logic b);
    logic [31:0] pb;
    pb = next_pc + 32'd4;
    ifc.alloc_a_valid = a; ifc.alloc_b_valid = b;
    ifc.alloc_a_pc = next_pc; ifc.alloc_b_pc = pb;
    ifc.alloc_a_old_phys = next_pc[7:2] + 6'd5; ifc.alloc_b_old_phys = pb[7:2] + 6'd5;
    ifc.alloc_a_has_dest = next_pc[4:2] != 3'd7; ifc.alloc_b_has_dest = pb[4:2] != 3'd7;
  endtask
  task automatic set_comp(input int p, input logic [3:0] r);
    if (p == 0) begin ifc.complete0_valid = 1; ifc.complete0_rob = r; end
    if (p == 1) begin ifc.complete1_valid = 1; ifc.complete1_rob = r; end
    if (p == 2) begin ifc.complete2_valid = 1; ifc.complete2_rob = r; end
  endtask
  // Advance the model on pre-edge state, clock once, then compare every output.
  task automatic tick();
    logic ra, rb, aa, ab;
    logic cvv [3];
    logic [3:0] crr [3];
    logic [3:0] h1;
    logic [38:0] e;
    ra = 0; rb = 0;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin mv[i] = 0; md[i] = 0; end
      m_head = 0; m_tail = 0; m_cnt = 0;
      sb.delete();
    end else begin
      h1 = m_head + 4'd1;
      ra = mv[m_head] && md[m_head];
      rb = ra && mv[h1] && md[h1];
      aa = ifc.alloc_a_valid && (m_cnt <= 14);
      ab = aa && ifc.alloc_b_valid;
      cvv[0] = ifc.complete0_valid; cvv[1] = ifc.complete1_valid; cvv[2] = ifc.complete2_valid;
      crr[0] = ifc.complete0_rob; crr[1] = ifc.complete1_rob; crr[2] = ifc.complete2_rob;
      for (int i = 0; i < 3; i++) if (cvv[i] && mv[crr[i]]) md[crr[i]] = 1;
      if (ra) begin mv[m_head] = 0; md[m_head] = 0; m_head = m_head + 4'd1; m_cnt--; end
      if (rb) begin mv[m_head] = 0; md[m_head] = 0; m_head = m_head + 4'd1; m_cnt--; end
      if (aa) begin
        mv[m_tail] = 1; md[m_tail] = 0; m_tail = m_tail + 4'd1; m_cnt++; next_pc += 4;
        sb.push_back({ifc.alloc_a_has_dest, ifc.alloc_a_old_phys, ifc.alloc_a_pc});
      end
      if (ab) begin
        mv[m_tail] = 1; md[m_tail] = 0; m_tail = m_tail + 4'd1; m_cnt++; next_pc += 4;
        sb.push_back({ifc.alloc_b_has_dest, ifc.alloc_b_old_phys, ifc.alloc_b_pc});
      end
    end
    @(posedge clk);
    #1;
    check("retire_a_valid", 64'(ifc.retire_a_valid), 64'(ra));
    check("retire_b_valid", 64'(ifc.retire_b_valid), 64'(rb));
    if (ra && ifc.retire_a_valid) begin
      if (sb.size() == 0) check("sb_underflow_a", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check("retire_a_data", 64'({ifc.retire_a_has_dest, ifc.retire_a_old_phys, ifc.retire_a_pc}), 64'(e));
      end
    end
    if (rb && ifc.retire_b_valid) begin
      if (sb.size() == 0) check("sb_underflow_b", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check("retire_b_data", 64'({ifc.retire_b_has_dest, ifc.retire_b_old_phys, ifc.retire_b_pc}), 64'(e));
      end
    end
    check("count", 64'(ifc.count), 64'(m_cnt));
    check("alloc_ready", 64'(ifc.alloc_ready), 64'(m_cnt <= 14));
    check("alloc_a_rob", 64'(ifc.alloc_a_rob), 64'(m_tail));
    check("alloc_b_rob", 64'(ifc.alloc_b_rob), 64'(m_tail + 4'd1));
    clear_inputs();
  endtask
  task automatic drain(input string tag);
    for (int t = 0; t < 40 && m_cnt != 0; t++) tick();
    check(tag, 64'(ifc.count), 64'd0);
  endtask
  initial begin
    logic [3:0] x, pa, pb;
    int c0;
    clear_inputs();
    reset = 1;
    tick();
    check("rst_retire_a_pc", 64'(ifc.retire_a_pc), 64'd0);
    check("rst_retire_b_old_phys", 64'(ifc.retire_b_old_phys), 64'd0);
    // First pair: pc 0/4, old_phys 5/6, completed out of order.
    set_alloc(1, 1);
    check("first_a_rob", 64'(ifc.alloc_a_rob), 64'd0);
    check("first_b_rob", 64'(ifc.alloc_b_rob), 64'd1);
    tick();
    check("first_count", 64'(ifc.count), 64'd2);
    tick();
    set_comp(0, 4'd1);
    tick();
    set_comp(0, 4'd0);
    tick();
    tick();
    check("pair_ret_a_old", 64'(ifc.retire_a_old_phys), 64'd5);
    check("pair_ret_b_old", 64'(ifc.retire_b_old_phys), 64'd6);
    check("pair_count", 64'(ifc.count), 64'd0);
    tick();
    // Fill to the top with no completions; excess requests are dropped.
    for (int i = 0; i < 10; i++) begin set_alloc(1, 1); tick(); end
    check("full_count", 64'(ifc.count), 64'd16);
    check("full_ready", 64'(ifc.alloc_ready), 64'd0);
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < 3; p++) if (3 * k + p < 16) set_comp(p, 4'(3 * k + p));
      tick();
    end
    drain("fill_drain");
    // Pipelined allocate/complete/retire across the wrap point.
    pa = 0; pb = 0;
    for (int i = 0; i < 20; i++) begin
      x = ifc.alloc_a_rob;
      set_alloc(1, 1);
      if (i > 0) begin set_comp(0, pa); set_comp(1, pb); end
      tick();
      pa = x; pb = x + 4'd1;
    end
    set_comp(0, pa); set_comp(1, pb);
    tick();
    drain("pairs_drain");
    // Allocate 2, retire 2 and complete 3 (one on a not-yet-valid entry) in one cycle.
    x = ifc.alloc_a_rob;
    set_alloc(1, 1);
    tick();
    set_comp(0, x); set_comp(1, x + 4'd1);
    tick();
    c0 = int'(ifc.count);
    set_alloc(1, 1);
    set_comp(0, x); set_comp(1, x + 4'd1); set_comp(2, ifc.alloc_a_rob);
    tick();
    check("combo_count", 64'(ifc.count), 64'(c0));
    tick();
    tick();
    set_comp(2, x + 4'd2); set_comp(1, x + 4'd3);
    tick();
    drain("combo_drain");
    // Reset with eight entries in flight.
    for (int i = 0; i < 4; i++) begin set_alloc(1, 1); tick(); end
    check("pre_reset_count", 64'(ifc.count), 64'd8);
    reset = 1;
    tick();
    check("post_reset_count", 64'(ifc.count), 64'd0);
    check("post_reset_a_rob", 64'(ifc.alloc_a_rob), 64'd0);
    check("post_reset_ret_a", 64'(ifc.retire_a_valid), 64'd0);
    tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
